// File: rtl/alu_share_sched_if.sv
// Request/response/ALU bus between the shared-ALU scheduler and its clients.
// The scheduler uses the slave view; requesters, responders and the ALU use master.
interface alu_share_sched_if;
  logic        req0_valid_i;
  logic        req0_ready_o;
  logic [31:0] req0_data1_i;
  logic [31:0] req0_data2_i;
  logic [2:0]  req0_ctrl_i;
  logic        req1_valid_i;
  logic        req1_ready_o;
  logic [31:0] req1_data1_i;
  logic [31:0] req1_data2_i;
  logic [2:0]  req1_ctrl_i;
  logic        resp0_valid_o;
  logic        resp0_ready_i;
  logic        resp1_valid_o;
  logic        resp1_ready_i;
  logic [31:0] resp_data_o;
  logic [31:0] alu_data1_o;
  logic [31:0] alu_data2_o;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] alu_data_i;
  logic        busy_o;
  logic [15:0] op_count_o;

  modport slave (
    input  req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
    input  req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
    input  resp0_ready_i, resp1_ready_i, alu_data_i,
    output req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o,
    output resp_data_o, alu_data1_o, alu_data2_o, alu_ctrl_o, busy_o, op_count_o
  );

  modport master (
    output req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
    output req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
    output resp0_ready_i, resp1_ready_i, alu_data_i,
    input  req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o,
    input  resp_data_o, alu_data1_o, alu_data2_o, alu_ctrl_o, busy_o, op_count_o
  );
endinterface

// File: rtl/alu_share_sched.sv
// Time-shares one combinational ALU between two requesters.
// IDLE grants round-robin, EXEC holds registered operands on the ALU
// (MUL for MUL_CYCLES cycles), RESP returns the result to the owner.
module alu_share_sched #(
  parameter int unsigned MUL_CYCLES = 3,
  parameter logic [2:0]  MUL_CODE   = 3'b101
) (
  input  logic             clk_i,
  input  logic             rst_i,
  alu_share_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t      state_q;
  logic        ptr_q;
  logic        owner_q;
  logic [31:0] d1_q, d2_q, rdata_q;
  logic [2:0]  ctrl_q;
  logic [3:0]  cnt_q;
  logic        busy_q, rv0_q, rv1_q;
  logic [15:0] ops_q;

  logic        gnt0, gnt1, rdy0, rdy1, own_rdy;
  logic [31:0] sel_d1, sel_d2;
  logic [2:0]  sel_ctrl;

  // Round-robin grant and capture mux; ready is held low while in reset
  always_comb begin
    gnt0     = bus.req0_valid_i && (!bus.req1_valid_i || !ptr_q);
    gnt1     = bus.req1_valid_i && (!bus.req0_valid_i ||  ptr_q);
    rdy0     = rst_i && (state_q == IDLE) && gnt0;
    rdy1     = rst_i && (state_q == IDLE) && gnt1;
    sel_d1   = rdy1 ? bus.req1_data1_i : bus.req0_data1_i;
    sel_d2   = rdy1 ? bus.req1_data2_i : bus.req0_data2_i;
    sel_ctrl = rdy1 ? bus.req1_ctrl_i  : bus.req0_ctrl_i;
    own_rdy  = owner_q ? bus.resp1_ready_i : bus.resp0_ready_i;
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      ops_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rdy0 || rdy1) begin
            d1_q    <= sel_d1;
            d2_q    <= sel_d2;
            ctrl_q  <= sel_ctrl;
            owner_q <= rdy1;
            cnt_q   <= (sel_ctrl == MUL_CODE) ? MUL_LOAD : 4'd0;
            state_q <= EXEC;
            busy_q  <= 1'b1;
          end
        end
        EXEC: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rdata_q <= bus.alu_data_i;
            rv0_q   <= !owner_q;
            rv1_q   <=  owner_q;
            state_q <= RESP;
          end
        end
        RESP: begin
          // Only the owner's ready completes the response
          if (own_rdy) begin
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            ptr_q   <= ~owner_q;
            ops_q   <= ops_q + 16'd1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready_o  = rdy0;
  assign bus.req1_ready_o  = rdy1;
  assign bus.resp0_valid_o = rv0_q;
  assign bus.resp1_valid_o = rv1_q;
  assign bus.resp_data_o   = rdata_q;
  assign bus.alu_data1_o   = d1_q;
  assign bus.alu_data2_o   = d2_q;
  assign bus.alu_ctrl_o    = ctrl_q;
  assign bus.busy_o        = busy_q;
  assign bus.op_count_o    = ops_q;

endmodule

// File: tb/tb_alu_share_sched.sv
// Directed bench for alu_share_sched with a response scoreboard.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
module tb_alu_share_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_sched_if bus();

  alu_share_sched #(.MUL_CYCLES(3), .MUL_CODE(3'b101)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic        glog[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_ops = '0;

  // Reference ALU: the external unit the scheduler drives
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return a + b;
      3'b101:  return a * b;
      3'b110:  return a - b;
      default: return a;
    endcase
  endfunction

  assign bus.alu_data_i = alu_f(bus.alu_data1_o, bus.alu_data2_o, bus.alu_ctrl_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on response handshake
  exp_t e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req0_valid_i && bus.req0_ready_o) begin
        sb.push_back('{1'b0, alu_f(bus.req0_data1_i, bus.req0_data2_i, bus.req0_ctrl_i)});
        glog.push_back(1'b0);
      end
      if (bus.req1_valid_i && bus.req1_ready_o) begin
        sb.push_back('{1'b1, alu_f(bus.req1_data1_i, bus.req1_data2_i, bus.req1_ctrl_i)});
        glog.push_back(1'b1);
      end
      if (bus.resp0_valid_o && bus.resp1_valid_o)
        chk("both_resp_valid", 32'd1, 32'd0);
      if ((bus.resp0_valid_o && bus.resp0_ready_i) || (bus.resp1_valid_o && bus.resp1_ready_i)) begin
        if (sb.size() == 0) begin
          chk("resp_without_req", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_owner", {31'd0, bus.resp1_valid_o}, {31'd0, e.owner});
          chk("resp_data", bus.resp_data_o, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    if (r == 0) begin
      bus.req0_valid_i = 1'b1; bus.req0_data1_i = a; bus.req0_data2_i = b; bus.req0_ctrl_i = c;
    end else begin
      bus.req1_valid_i = 1'b1; bus.req1_data1_i = a; bus.req1_data2_i = b; bus.req1_ctrl_i = c;
    end
  endtask

  task automatic wait_acc(input int r);
    bit got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if ((r == 0) ? bus.req0_ready_o : bus.req1_ready_o) got = 1;
      tick();
    end
    if (!got) chk("accept_timeout", 32'd1, 32'd0);
    if (r == 0) bus.req0_valid_i = 1'b0; else bus.req1_valid_i = 1'b0;
  endtask

  // Count edges from accept to response valid; ALU inputs must hold meanwhile
  task automatic wait_resp(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] c, output int n);
    bit got = 0;
    n = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if ((r == 0) ? bus.resp0_valid_o : bus.resp1_valid_o) begin
        got = 1;
      end else begin
        chk("exec_alu_d1", bus.alu_data1_o, a);
        chk("exec_alu_d2", bus.alu_data2_o, b);
        chk("exec_alu_ctrl", {29'd0, bus.alu_ctrl_o}, {29'd0, c});
        chk("exec_busy", {31'd0, bus.busy_o}, 32'd1);
        @(posedge clk);
        n++;
      end
    end
    if (!got) chk("resp_timeout", 32'd1, 32'd0);
    #2;
  endtask

  task automatic op(input int r, input logic [31:0] a, input logic [31:0] b,
                    input logic [2:0] c, input int lat);
    int n;
    drive(r, a, b, c);
    wait_acc(r);
    wait_resp(r, a, b, c, n);
    chk("latency", n, lat);
    tick();
    exp_ops = exp_ops + 16'd1;
    chk("op_count", {16'd0, bus.op_count_o}, {16'd0, exp_ops});
    chk("idle_busy", {31'd0, bus.busy_o}, 32'd0);
  endtask

  initial begin
    int n;
    int acc;
    bit done;
    bus.req0_valid_i = 1'b1; bus.req0_data1_i = '0; bus.req0_data2_i = '0; bus.req0_ctrl_i = '0;
    bus.req1_valid_i = 1'b0; bus.req1_data1_i = '0; bus.req1_data2_i = '0; bus.req1_ctrl_i = '0;
    bus.resp0_ready_i = 1'b1; bus.resp1_ready_i = 1'b1;

    // Reset state, with a request pending to prove ready is gated
    #12;
    chk("rst_ready0", {31'd0, bus.req0_ready_o}, 32'd0);
    chk("rst_ready1", {31'd0, bus.req1_ready_o}, 32'd0);
    chk("rst_resp0", {31'd0, bus.resp0_valid_o}, 32'd0);
    chk("rst_resp1", {31'd0, bus.resp1_valid_o}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_ops", {16'd0, bus.op_count_o}, 32'd0);
    chk("rst_rdata", bus.resp_data_o, 32'd0);
    chk("rst_alu_d1", bus.alu_data1_o, 32'd0);
    chk("rst_alu_ctrl", {29'd0, bus.alu_ctrl_o}, 32'd0);
    bus.req0_valid_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Reset in the middle of a MUL aborts it
    drive(1, 32'd9, 32'd9, 3'b101);
    wait_acc(1);
    @(negedge clk);
    chk("mid_busy", {31'd0, bus.busy_o}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("abort_resp1", {31'd0, bus.resp1_valid_o}, 32'd0);
    chk("abort_alu_ctrl", {29'd0, bus.alu_ctrl_o}, 32'd0);
    sb.delete();
    glog.delete();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_resp", {30'd0, bus.resp1_valid_o, bus.resp0_valid_o}, 32'd0);
    end
    chk("abort_ops", {16'd0, bus.op_count_o}, 32'd0);
    tick();

    // Single ops: ADD, MUL, SUB and an unknown code passed through
    op(0, 32'd5, 32'd7, 3'b011, 1);
    op(1, 32'd6, 32'd7, 3'b101, 3);
    op(0, 32'd100, 32'd250, 3'b110, 1);
    op(1, 32'hDEAD_BEEF, 32'd1, 3'b111, 1);

    // Both valid, pointer back at 0: strict alternation 0,1,0,1
    glog.delete();
    drive(0, 32'd3, 32'd4, 3'b011);
    drive(1, 32'd10, 32'd3, 3'b101);
    acc = 0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.req0_ready_o || bus.req1_ready_o) acc++;
      tick();
      if (acc == 4) done = 1;
    end
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    chk("rr_done", {31'd0, done}, 32'd1);
    for (int i = 0; i < 50 && (bus.busy_o || sb.size() != 0); i++) tick();
    chk("rr_grants", glog.size(), 32'd4);
    if (glog.size() == 4) begin
      chk("rr_g0", {31'd0, glog[0]}, 32'd0);
      chk("rr_g1", {31'd0, glog[1]}, 32'd1);
      chk("rr_g2", {31'd0, glog[2]}, 32'd0);
      chk("rr_g3", {31'd0, glog[3]}, 32'd1);
    end
    exp_ops = exp_ops + 16'd4;
    chk("rr_ops", {16'd0, bus.op_count_o}, {16'd0, exp_ops});

    // Back-pressure on requester 0 while requester 1 waits
    bus.resp0_ready_i = 1'b0;
    drive(0, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000);
    wait_acc(0);
    drive(1, 32'd100, 32'd1, 3'b011);
    wait_resp(0, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000, n);
    chk("bp_latency", n, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp0", {31'd0, bus.resp0_valid_o}, 32'd1);
      chk("bp_resp1", {31'd0, bus.resp1_valid_o}, 32'd0);
      chk("bp_data", bus.resp_data_o, 32'h00F0_1234);
      chk("bp_ready", {30'd0, bus.req1_ready_o, bus.req0_ready_o}, 32'd0);
      tick();
    end
    bus.resp0_ready_i = 1'b1;
    tick();
    wait_acc(1);
    wait_resp(1, 32'd100, 32'd1, 3'b011, n);
    chk("bp_r1_latency", n, 32'd1);
    tick();
    exp_ops = exp_ops + 16'd2;
    chk("bp_ops", {16'd0, bus.op_count_o}, {16'd0, exp_ops});

    // Completion counter wraps from 0xFFFF to 0
    force dut.ops_q = 16'hFFFF;
    #1;
    release dut.ops_q;
    exp_ops = 16'hFFFF;
    chk("wrap_pre", {16'd0, bus.op_count_o}, 32'h0000_FFFF);
    op(0, 32'd1, 32'd1, 3'b011, 1);
    chk("wrap_post", {16'd0, bus.op_count_o}, 32'd0);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_sched.md
Name: alu_share_sched

Overview:
Scheduler that time-shares one combinational ALU between two requesters, e.g. the main pipeline EX stage and an auxiliary address/loop unit. Each requester hands over an operand pair and a 3-bit ALU control code through a valid/ready handshake. The block drives the shared ALU from registered operands and holds MUL for a configurable number of cycles to meet timing. It returns the result to the originating requester over a response handshake and arbitrates round-robin.

Parameters:
MUL_CYCLES, 3, cycles the ALU is held for a MUL op (legal range 1..15)
MUL_CODE, 3'b101, ALU control code treated as multi-cycle

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
req0_valid_i  in  1  requester 0 has an op
req0_ready_o  out  1  scheduler accepts requester 0 op this cycle
req0_data1_i  in  32  requester 0 operand 1
req0_data2_i  in  32  requester 0 operand 2
req0_ctrl_i  in  3  requester 0 ALU control code
req1_valid_i, req1_ready_o, req1_data1_i, req1_data2_i, req1_ctrl_i  same as above, requester 1
resp0_valid_o  out  1  result for requester 0 is valid
resp0_ready_i  in  1  requester 0 takes the result
resp1_valid_o  out  1  result for requester 1 is valid
resp1_ready_i  in  1  requester 1 takes the result
resp_data_o  out  32  result, shared by both response ports
alu_data1_o  out  32  operand 1 to the shared ALU
alu_data2_o  out  32  operand 2 to the shared ALU
alu_ctrl_o  out  3  control code to the shared ALU
alu_data_i  in  32  result from the shared ALU
busy_o  out  1  high when the state is not IDLE
op_count_o  out  16  count of completed responses

Behaviour:
- Reset (rst_i=0, immediate): state=IDLE, priority pointer=0, owner=0. All ready/valid/busy outputs are 0. resp_data_o, alu_* outputs, operand registers and op_count_o are 0.
- Reset mid-operation aborts the in-flight op. No response is issued and nothing is counted.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - Grant is combinational. If only one valid is high, that requester gets the grant. If both are high, the requester indicated by the pointer gets the grant. If neither is high, there is no grant.
  - reqN_ready_o = (state==IDLE) && grant==N. It is never high in EXEC or RESP.
  - On valid&&ready: capture data1, data2, ctrl and owner=N. Load the counter with MUL_CYCLES-1 if ctrl==MUL_CODE, otherwise 0. Go to EXEC.
- alu_data1_o, alu_data2_o and alu_ctrl_o come straight from the capture registers. They are stable for the whole of EXEC and keep their last values otherwise.
- EXEC:
  - If the counter is not 0, decrement it.
  - If the counter is 0, register alu_data_i into resp_data_o and go to RESP.
  - Occupancy is 1 cycle for a non-MUL op and MUL_CYCLES cycles for MUL.
  - Codes other than MUL_CODE, including unknown codes, are single-cycle and pass through unchanged.
- RESP:
  - resp<owner>_valid_o=1. The other response valid is 0.
  - valid and resp_data_o are held until resp<owner>_ready_i is sampled high.
  - On handshake: go to IDLE, set pointer = ~owner so the just-served requester gets lowest priority, and do op_count_o+1 (wraps 0xFFFF->0).
  - resp_ready_i of the non-owner is ignored.
- Latency: an accept at edge T gives response valid visible after edge T+1 (non-MUL) or T+MUL_CYCLES (MUL). With ready held high, the handshake completes at the next edge and a new accept is possible the following cycle. Best-case throughput is 1 op per 3 cycles.
- busy_o is registered and equals (state != IDLE).
- Requesters must hold valid and operands stable until ready. Dropping valid before ready is allowed; nothing is captured.

Test Plan:
1. Reset then idle -> all ready/valid=0, op_count_o=0, busy_o=0. Assert rst_i low mid-MUL -> no response, busy_o=0 immediately, op_count_o unchanged.
2. Req0 ADD (3'b011) 5+7, resp0_ready_i=1 -> accepted in cycle 0, alu_ctrl_o=3'b011 in cycle 1, resp0_valid_o=1 with resp_data_o=12 after the next edge, resp1_valid_o=0, op_count_o=1.
3. Req1 MUL (3'b101) 6*7 with MUL_CYCLES=3 -> ALU inputs stable for 3 EXEC cycles, resp1_valid_o rises 3 cycles after accept, resp_data_o=42.
4. Both valid at once, pointer=0 -> req0 granted first. Both stay valid -> req1 is granted next, then req0, strictly alternating over 4 ops.
5. Back-pressure: resp0_ready_i=0 for 5 cycles -> resp0_valid_o and resp_data_o held, both req ready=0, req1 waiting is not accepted until the handshake.
6. Drive 65536 completed ops (or force op_count_o=0xFFFF) -> the next completion wraps op_count_o to 0.
